// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side drain engine for a Standard_FIFO.
// It pulls words over the FIFO's rd/empty/r_data interface and presents them
// as a first-word-fall-through valid/ready stream at one word per cycle.
// Optional build macro FIFO_STREAM_READER_CNT_EN adds the 16-bit rd_count
// output, which counts accepted stream words and wraps.
//
// state       | meaning
// inflight=1  | a FIFO read was accepted last edge; its word is on fifo_r_data now
// occ=0       | holding buffer empty, m_valid low
// occ=1       | one word buffered, presented on m_data
// occ=2       | buffer full, no new reads unless a pop is happening
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_STREAM_READER_CNT_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  // The pointer and occupancy widths below only cover a two-entry buffer.
  generate
    if (BUF_DEPTH != 2) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be 2");
    end
  endgenerate

  logic                  inflight;
  logic [1:0]            occ;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buf_mem [0:1];
  logic                  pop;
  logic [2:0]            level_next;

  // Stream side: valid whenever anything is buffered, data is the buffer head.
  always_comb begin
    m_valid = (occ != 2'd0);
    m_data  = buf_mem[head];
  end

  // Read request: only issue a read if the word it returns is guaranteed a
  // slot. Looking at this cycle's pop keeps the pipe full under steady ready.
  always_comb begin
    pop        = m_valid & m_ready;
    level_next = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    fifo_rd    = !reset && !fifo_empty && (level_next < 3'd2);
  end

  // Capture the returning word, advance pointers and track occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      occ        <= 2'd0;
      head       <= 1'b0;
      tail       <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      if (inflight) begin
        buf_mem[tail] <= fifo_r_data;
        tail          <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      inflight <= fifo_rd & !fifo_empty;
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  // Count accepted stream words; wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= 16'd0;
    end else if (pop) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`else
  // Default build carries no pop counter.
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: behavioural upstream FIFO, ordered
// scoreboard of written words, and a negedge monitor that does all checking.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_rd;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
`ifdef FIFO_STREAM_READER_CNT_EN
  logic [15:0] rd_count;
`endif

  // upstream FIFO model storage
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr;
  logic [7:0] delivered;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] got;
    logic [31:0] req;
  } chk_t;

  chk_t       chk_q [$];
  logic [7:0] exp_q [$];
  chk_t       mon_c;
  logic [7:0] mon_e;

  fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .fifo_r_data(fifo_r_data),
    .fifo_rd    (fifo_rd),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_STREAM_READER_CNT_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Standard_FIFO read side: word appears the cycle after an accepted read;
  // otherwise the data bus carries junk.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= 8'd0;
      fifo_r_data <= 8'd0;
    end else if (fifo_rd && !fifo_empty) begin
      fifo_r_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 8'd1;
    end else begin
      fifo_r_data <= 8'($urandom);
    end
  end

  // Monitor: scoreboard compare on each handshake, occupancy bound, and
  // evaluation of the directed checks posted by the stimulus.
  always @(negedge clk) begin
    if (reset) begin
      delivered = 8'd0;
    end else begin
      checks++;
      if (8'(rd_ptr - delivered) > 8'd2) begin
        errors++;
        $display("FAIL occupancy: words held %0d, required at most 2", 8'(rd_ptr - delivered));
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream word: got 0x%02h, required no word", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_data !== mon_e) begin
            errors++;
            $display("FAIL stream word: got 0x%02h, required 0x%02h", m_data, mon_e);
          end
        end
        delivered = delivered + 8'd1;
      end
    end
    while (chk_q.size() > 0) begin
      mon_c = chk_q.pop_front();
      checks++;
      if (mon_c.got !== mon_c.req) begin
        errors++;
        $display("FAIL %s: got 0x%0h, required 0x%0h", mon_c.name, mon_c.got, mon_c.req);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    mem[wr_ptr] = d;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] req);
    chk_t c;
    c.name = name;
    c.got  = got;
    c.req  = req;
    chk_q.push_back(c);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    expect_eq(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [7:0] base;

    reset   = 1'b0;
    m_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) step();
    expect_eq("reset m_valid", 32'(m_valid), 32'd0);
    expect_eq("reset fifo_rd", 32'(fifo_rd), 32'd0);
    expect_eq("reset m_data", 32'(m_data), 32'd0);
    reset = 1'b0;
    repeat (3) step();
    expect_eq("idle m_valid", 32'(m_valid), 32'd0);
    expect_eq("idle fifo_rd", 32'(fifo_rd), 32'd0);

    // streaming with ready held high
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push_word(8'(i));
    n = 0;
    while (!m_valid && n < 10) begin
      step();
      n++;
    end
    expect_eq("stream latency", 32'(n), 32'd2);
    n = 0;
    while (m_valid && n < 40) begin
      step();
      n++;
    end
    expect_eq("stream valid run", 32'(n), 32'd16);
    expect_eq("stream all delivered", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    expect_eq("ready while idle", 32'(m_valid), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    expect_eq("rd_count after stream", 32'(rd_count), 32'd16);
`endif

    // backpressure
    m_ready = 1'b0;
    base    = rd_ptr;
    for (int i = 1; i <= 5; i++) push_word(8'(i));
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) expect_eq("bp head held", 32'(m_data), 32'h01);
    end
    expect_eq("bp read count", 32'(8'(rd_ptr - base)), 32'd2);
    expect_eq("bp fifo_rd low", 32'(fifo_rd), 32'd0);
    expect_eq("bp m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    drain("bp drain", 40);
    step();
    expect_eq("bp end m_valid", 32'(m_valid), 32'd0);

    // alternating ready
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    m_ready = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      m_ready = ~m_ready;
      step();
      n++;
    end
    expect_eq("alt drain", 32'(exp_q.size()), 32'd0);

    // random writes and random ready
    for (int i = 0; i < 300; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0 && wr_ptr < 8'd230) push_word(8'($urandom));
      step();
    end
    m_ready = 1'b1;
    drain("random drain", 60);

    // empty / refill with single words
    m_ready = 1'b0;
    repeat (3) step();
    base = rd_ptr;
    push_word(8'h17);
    repeat (4) step();
    expect_eq("refill1 reads", 32'(8'(rd_ptr - base)), 32'd1);
    expect_eq("refill1 m_valid", 32'(m_valid), 32'd1);
    expect_eq("refill1 m_data", 32'(m_data), 32'h17);
    m_ready = 1'b1;
    step();
    expect_eq("refill1 taken", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    repeat (2) step();
    base = rd_ptr;
    push_word(8'h18);
    repeat (4) step();
    expect_eq("refill2 reads", 32'(8'(rd_ptr - base)), 32'd1);
    expect_eq("refill2 m_data", 32'(m_data), 32'h18);
    m_ready = 1'b1;
    step();
    expect_eq("refill2 taken", 32'(m_valid), 32'd0);

    // reset mid-cycle with two words buffered
    m_ready = 1'b0;
    base    = rd_ptr;
    for (int i = 0; i < 3; i++) push_word(8'($urandom_range(1, 255)));
    repeat (5) step();
    expect_eq("pre-reset m_valid", 32'(m_valid), 32'd1);
    expect_eq("pre-reset reads", 32'(8'(rd_ptr - base)), 32'd2);
    #2;
    wr_ptr = 8'd0;
    exp_q.delete();
    reset = 1'b1;
    #1;
    expect_eq("async reset m_valid", 32'(m_valid), 32'd0);
    expect_eq("async reset m_data", 32'(m_data), 32'd0);
    expect_eq("async reset fifo_rd", 32'(fifo_rd), 32'd0);
`ifdef FIFO_STREAM_READER_CNT_EN
    expect_eq("async reset rd_count", 32'(rd_count), 32'd0);
`endif
    repeat (2) step();
    reset = 1'b0;
    repeat (3) step();
    expect_eq("post-reset m_valid", 32'(m_valid), 32'd0);
    expect_eq("post-reset m_data", 32'(m_data), 32'd0);
    expect_eq("post-reset fifo_rd", 32'(fifo_rd), 32'd0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
